// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipelined core: runs loads/stores over a req/done
// handshake and presents results to writeback through one MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_wb_en,
  input  logic [2:0]  ex_wb_reg,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_data,
  output logic        wb_en,
  output logic [2:0]  wb_reg,
  output logic        err
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid and its payload hold stable until that edge; ready never waits on valid.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       cap_wb_en;
  logic [2:0] cap_wb_reg;

  logic accept;
  logic is_mem;
  logic bad_op;
  logic go_busy;
  logic mem_finish;

  assign ex_ready   = rst_n & (state_q == IDLE) & (~wb_valid | wb_ready);
  assign accept     = ex_valid & ex_ready;
  assign is_mem     = ex_mem_rd | ex_mem_wr;
  assign bad_op     = is_mem & ((ex_mem_rd & ex_mem_wr) | ex_alu_out[0]);
  assign go_busy    = accept & is_mem & ~bad_op;
  assign mem_finish = (state_q == BUSY) & mem_done;
  assign mem_req    = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_busy) state_d = BUSY;
      BUSY:    if (mem_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request fields and pending writeback fields are captured only on entry to BUSY,
  // so they stay frozen for the whole access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wr     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      cap_wb_en  <= 1'b0;
      cap_wb_reg <= 3'd0;
      err        <= 1'b0;
    end else begin
      if (go_busy) begin
        mem_wr     <= ex_mem_wr;
        mem_addr   <= ex_alu_out;
        mem_wdata  <= ex_store_data;
        cap_wb_en  <= ex_wb_en;
        cap_wb_reg <= ex_wb_reg;
      end
      if (accept & bad_op) err <= 1'b1;
    end
  end

  // The effective address doubles as the captured ALU result for store writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= 16'h0000;
      wb_en    <= 1'b0;
      wb_reg   <= 3'd0;
    end else if (accept & ~is_mem) begin
      wb_valid <= 1'b1;
      wb_data  <= ex_alu_out;
      wb_en    <= ex_wb_en;
      wb_reg   <= ex_wb_reg;
    end else if (mem_finish) begin
      wb_valid <= 1'b1;
      wb_data  <= mem_wr ? mem_addr : mem_rdata;
      wb_en    <= cap_wb_en;
      wb_reg   <= cap_wb_reg;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for ALU-op flow and backpressure,
// plus hand-written load/store/error/reset sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_alu_out;
  logic [15:0] ex_store_data;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_wb_en;
  logic [2:0]  ex_wb_reg;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                          input logic rd, input logic wr, input logic en,
                          input logic [2:0] rg);
    ex_valid      = v;
    ex_alu_out    = alu;
    ex_store_data = sd;
    ex_mem_rd     = rd;
    ex_mem_wr     = wr;
    ex_wb_en      = en;
    ex_wb_reg     = rg;
  endtask

  task automatic ex_idle();
    drive_ex(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] alu;
    logic        en;
    logic [2:0]  rg;
    logic        rdy;
    logic        exp_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_en;
    logic [2:0]  exp_reg;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] addr_hold;

    tbl[0] = '{1'b1, 16'h1234, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd5};
    tbl[1] = '{1'b1, 16'h0001, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 3'd1};
    tbl[2] = '{1'b1, 16'hFFFF, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 3'd7};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0};
    tbl[4] = '{1'b1, 16'h00AA, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 16'h00AA, 1'b1, 3'd3};
    tbl[5] = '{1'b1, 16'h0BAD, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 16'h00AA, 1'b1, 3'd3};
    tbl[6] = '{1'b1, 16'h0C0D, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 16'h0C0D, 1'b0, 3'd2};
    tbl[7] = '{1'b1, 16'h8000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 3'd0};

    rst_n = 1'b0;
    ex_idle();
    ex_valid  = 1'b1;
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    wb_ready  = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_ex_ready", {15'd0, ex_ready}, 16'd0);
    chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_wb_data", wb_data, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    rst_n = 1'b1;
    ex_idle();
    tick();

    // ALU-op table: back-to-back retire, then backpressure and same-edge replace
    for (int i = 0; i < 8; i++) begin
      drive_ex(tbl[i].v, tbl[i].alu, 16'h0000, 1'b0, 1'b0, tbl[i].en, tbl[i].rg);
      wb_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_ex_ready", i), {15'd0, ex_ready}, {15'd0, tbl[i].exp_ready});
      tick();
      chk($sformatf("vec%0d_wb_valid", i), {15'd0, wb_valid}, {15'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_mem_req", i), {15'd0, mem_req}, 16'd0);
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].exp_data);
        chk($sformatf("vec%0d_wb_en", i), {15'd0, wb_en}, {15'd0, tbl[i].exp_en});
        chk($sformatf("vec%0d_wb_reg", i), {13'd0, wb_reg}, {13'd0, tbl[i].exp_reg});
      end
    end

    // Load at 0x0040: mem_done in the third BUSY cycle
    wb_ready = 1'b1;
    drive_ex(1'b1, 16'h0040, 16'h1111, 1'b1, 1'b0, 1'b1, 3'd4);
    #1;
    chk("ld_accept_ready", {15'd0, ex_ready}, 16'd1);
    tick();
    ex_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ld_req_c%0d", i), {15'd0, mem_req}, 16'd1);
      chk($sformatf("ld_addr_c%0d", i), mem_addr, 16'h0040);
      chk($sformatf("ld_wr_c%0d", i), {15'd0, mem_wr}, 16'd0);
      chk($sformatf("ld_wdata_c%0d", i), mem_wdata, 16'h1111);
      chk($sformatf("ld_ex_ready_c%0d", i), {15'd0, ex_ready}, 16'd0);
      chk($sformatf("ld_wb_valid_c%0d", i), {15'd0, wb_valid}, 16'd0);
      if (i == 2) begin
        mem_done  = 1'b1;
        mem_rdata = 16'hBEEF;
      end
      tick();
    end
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    chk("ld_req_drop", {15'd0, mem_req}, 16'd0);
    chk("ld_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    chk("ld_wb_en", {15'd0, wb_en}, 16'd1);
    chk("ld_wb_reg", {13'd0, wb_reg}, 16'd4);

    // Store 0xA5A5 to 0x0010, done in the first BUSY cycle; accepted as the load result drains
    drive_ex(1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 3'd6);
    #1;
    chk("st_accept_ready", {15'd0, ex_ready}, 16'd1);
    tick();
    ex_idle();
    mem_done  = 1'b1;
    mem_rdata = 16'h7777;
    #1;
    chk("st_req", {15'd0, mem_req}, 16'd1);
    chk("st_wr", {15'd0, mem_wr}, 16'd1);
    chk("st_wdata", mem_wdata, 16'hA5A5);
    chk("st_addr", mem_addr, 16'h0010);
    chk("st_busy_wb_valid", {15'd0, wb_valid}, 16'd0);
    tick();
    mem_done = 1'b0;
    chk("st_req_drop", {15'd0, mem_req}, 16'd0);
    chk("st_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("st_wb_data", wb_data, 16'h0010);
    chk("st_wb_en", {15'd0, wb_en}, 16'd0);
    chk("st_wb_reg", {13'd0, wb_reg}, 16'd6);

    // Writeback stall for 4 cycles, then release together with a new ALU op
    wb_ready = 1'b0;
    drive_ex(1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stall_ex_ready_c%0d", i), {15'd0, ex_ready}, 16'd0);
      tick();
      chk($sformatf("stall_valid_c%0d", i), {15'd0, wb_valid}, 16'd1);
      chk($sformatf("stall_data_c%0d", i), wb_data, 16'h0010);
      chk($sformatf("stall_reg_c%0d", i), {13'd0, wb_reg}, 16'd6);
    end
    wb_ready = 1'b1;
    #1;
    chk("release_ex_ready", {15'd0, ex_ready}, 16'd1);
    tick();
    ex_idle();
    chk("release_valid", {15'd0, wb_valid}, 16'd1);
    chk("release_data", wb_data, 16'h5555);
    chk("release_reg", {13'd0, wb_reg}, 16'd1);
    chk("release_en", {15'd0, wb_en}, 16'd1);

    // Stray mem_done while idle must not start or retire anything
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("idle_done_req", {15'd0, mem_req}, 16'd0);
    chk("idle_done_valid", {15'd0, wb_valid}, 16'd0);
    tick();
    chk("idle_done_valid2", {15'd0, wb_valid}, 16'd0);

    // Unaligned load at 0x0021
    drive_ex(1'b1, 16'h0021, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    ex_idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("unal_req_c%0d", i), {15'd0, mem_req}, 16'd0);
      chk($sformatf("unal_valid_c%0d", i), {15'd0, wb_valid}, 16'd0);
      chk($sformatf("unal_err_c%0d", i), {15'd0, err}, 16'd1);
      chk($sformatf("unal_ex_ready_c%0d", i), {15'd0, ex_ready}, 16'd1);
      tick();
    end
    do_reset();
    chk("err_cleared", {15'd0, err}, 16'd0);

    // Load and store flags both set
    drive_ex(1'b1, 16'h0030, 16'h1234, 1'b1, 1'b1, 1'b1, 3'd3);
    tick();
    ex_idle();
    chk("rdwr_req", {15'd0, mem_req}, 16'd0);
    chk("rdwr_valid", {15'd0, wb_valid}, 16'd0);
    chk("rdwr_err", {15'd0, err}, 16'd1);
    tick();
    chk("rdwr_err_hold", {15'd0, err}, 16'd1);
    do_reset();
    chk("rdwr_err_cleared", {15'd0, err}, 16'd0);

    // Reset in the middle of a load abandons it; a late mem_done is ignored
    drive_ex(1'b1, 16'h0008, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd7);
    tick();
    ex_idle();
    addr_hold = mem_addr;
    chk("mid_req", {15'd0, mem_req}, 16'd1);
    chk("mid_addr", addr_hold, 16'h0008);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ex_ready", {15'd0, ex_ready}, 16'd0);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_req", {15'd0, mem_req}, 16'd0);
    chk("mid_rst_valid", {15'd0, wb_valid}, 16'd0);
    mem_done  = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0;
    chk("late_done_req", {15'd0, mem_req}, 16'd0);
    chk("late_done_valid", {15'd0, wb_valid}, 16'd0);
    chk("late_done_err", {15'd0, err}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
